// File: rtl/rough_estimate.sv
// -----------------------------------------------------------------------------
// rough_estimate
//   Registered initial-guess stage for the single-precision square-root
//   datapath. The operand is classified as NaN, +/-inf, +/-0, negative,
//   denormal or normal. A coarse root is formed by halving the unbiased
//   exponent and shifting the fraction right by one. The result seeds the
//   Newton refinement stages that follow this block.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset; clears all outputs
//   in_sign       operand sign
//   in_exponent   operand biased exponent (8 bits)
//   in_mantissa   operand fraction, hidden bit not included (23 bits)
//   out_sign      estimate sign
//   out_exponent  estimate biased exponent
//   out_mantissa  estimate fraction
//   incorrect     operand has no real root (NaN or negative nonzero)
//
// Configuration
//   ROUGH_ESTIMATE_DENORM_EN  when defined, positive denormals are normalized
//                             before the estimate is formed. Otherwise they
//                             flush to +0.
// -----------------------------------------------------------------------------
module rough_estimate (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_sign,
  input  logic [7:0]  in_exponent,
  input  logic [22:0] in_mantissa,
  output logic        out_sign,
  output logic [7:0]  out_exponent,
  output logic [22:0] out_mantissa,
  output logic        incorrect
);

  localparam logic [30:0] QNAN_BITS = 31'h7FC00000;
  localparam logic [30:0] PINF_BITS = 31'h7F800000;

  // Estimate rule applied to an unbiased exponent e and a fraction f. The
  // value of e lies in [-149,127], so 9 signed bits are enough. The field
  // e[8:1] is the floor half of e. The rebias is done modulo 256, which is
  // safe because the result always falls in [1,190]. The low bit of e
  // selects whether the implicit 0.5 is folded into the fraction.
  function automatic logic [30:0] estimate(input logic signed [8:0] e,
                                           input logic [22:0]       f);
    logic [7:0] half_exp;
    half_exp = e[8:1] + 8'd127;
    estimate = {half_exp, e[0], f[22:1]};
  endfunction

`ifdef ROUGH_ESTIMATE_DENORM_EN
  // Position of the leading one. The caller guarantees that m is nonzero.
  function automatic logic [4:0] lead_pos(input logic [22:0] m);
    lead_pos = 5'd0;
    for (int i = 0; i < 23; i++) begin
      if (m[i]) lead_pos = 5'(i);
    end
  endfunction

  logic [4:0]        den_pos;
  logic [4:0]        den_shift;
  logic signed [8:0] den_e;
  logic [22:0]       den_f;

  always_comb begin
    den_pos   = lead_pos(in_mantissa);
    den_shift = 5'd23 - den_pos;
    den_e     = $signed({4'b0000, den_pos}) - 9'sd149;
    // Shifting by (23 - p) pushes the leading one out of the field, so the
    // leading one becomes the hidden bit.
    den_f     = in_mantissa << den_shift;
  end
`endif

  logic signed [8:0] norm_e;
  logic              exp_all_ones;
  logic              exp_zero;
  logic              mant_zero;

  logic        out_sign_d,     out_sign_q;
  logic [7:0]  out_exponent_d, out_exponent_q;
  logic [22:0] out_mantissa_d, out_mantissa_q;
  logic        incorrect_d,    incorrect_q;

  always_comb begin
    logic [30:0] mag;
    norm_e       = $signed({1'b0, in_exponent}) - 9'sd127;
    exp_all_ones = (in_exponent == 8'hFF);
    exp_zero     = (in_exponent == 8'h00);
    mant_zero    = (in_mantissa == 23'd0);

    out_sign_d  = 1'b0;
    mag         = 31'd0;
    incorrect_d = 1'b0;

    // The checks are in priority order.
    if (exp_all_ones && !mant_zero) begin
      mag         = QNAN_BITS;
      incorrect_d = 1'b1;
    end else if (exp_all_ones && in_sign) begin
      mag         = QNAN_BITS;
      incorrect_d = 1'b1;
    end else if (exp_all_ones) begin
      mag         = PINF_BITS;
    end else if (exp_zero && mant_zero) begin
      // The sign is kept so that sqrt(-0) = -0.
      out_sign_d  = in_sign;
    end else if (in_sign) begin
      mag         = QNAN_BITS;
      incorrect_d = 1'b1;
    end else if (exp_zero) begin
`ifdef ROUGH_ESTIMATE_DENORM_EN
      mag         = estimate(den_e, den_f);
`else
      mag         = 31'd0;
`endif
    end else begin
      mag         = estimate(norm_e, in_mantissa);
    end

    out_exponent_d = mag[30:23];
    out_mantissa_d = mag[22:0];
  end

  // Register stage. Reset clears both the data and the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sign_q     <= 1'b0;
      out_exponent_q <= 8'd0;
      out_mantissa_q <= 23'd0;
      incorrect_q    <= 1'b0;
    end else begin
      out_sign_q     <= out_sign_d;
      out_exponent_q <= out_exponent_d;
      out_mantissa_q <= out_mantissa_d;
      incorrect_q    <= incorrect_d;
    end
  end

  assign out_sign     = out_sign_q;
  assign out_exponent = out_exponent_q;
  assign out_mantissa = out_mantissa_q;
  assign incorrect    = incorrect_q;

endmodule

// File: tb/tb_rough_estimate.sv
module tb_rough_estimate;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_sign;
  logic [7:0]  in_exponent;
  logic [22:0] in_mantissa;
  logic        out_sign;
  logic [7:0]  out_exponent;
  logic [22:0] out_mantissa;
  logic        incorrect;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rough_estimate dut (
    .clk          (clk),
    .rst          (rst),
    .in_sign      (in_sign),
    .in_exponent  (in_exponent),
    .in_mantissa  (in_mantissa),
    .out_sign     (out_sign),
    .out_exponent (out_exponent),
    .out_mantissa (out_mantissa),
    .incorrect    (incorrect)
  );

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
    logic        inc;
  } vec_t;

  vec_t vecs[20];

  task automatic drive(input logic [31:0] w);
    {in_sign, in_exponent, in_mantissa} = w;
  endtask

  task automatic check(input string name, input logic [31:0] exp_w, input logic exp_inc);
    logic [31:0] act;
    act = {out_sign, out_exponent, out_mantissa};
    checks++;
    if (act !== exp_w || incorrect !== exp_inc) begin
      errors++;
      $display("FAIL %s: got %08h/%0b expected %08h/%0b", name, act, incorrect, exp_w, exp_inc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{32'h00000000, 32'h00000000, 1'b0};
    vecs[1]  = '{32'h80000000, 32'h80000000, 1'b0};
    vecs[2]  = '{32'h7F800000, 32'h7F800000, 1'b0};
    vecs[3]  = '{32'hFF800000, 32'h7FC00000, 1'b1};
    vecs[4]  = '{32'h7FA6ED6A, 32'h7FC00000, 1'b1};
    vecs[5]  = '{32'h42800000, 32'h41000000, 1'b0};
    vecs[6]  = '{32'h3D800000, 32'h3E800000, 1'b0};
    vecs[7]  = '{32'h4745C100, 32'h4362E080, 1'b0};
    vecs[8]  = '{32'h40000000, 32'h3FC00000, 1'b0};
    vecs[9]  = '{32'hC1200000, 32'h7FC00000, 1'b1};
`ifdef ROUGH_ESTIMATE_DENORM_EN
    vecs[10] = '{32'h00000001, 32'h1A400000, 1'b0};
    vecs[11] = '{32'h00400000, 32'h1FC00000, 1'b0};
`else
    vecs[10] = '{32'h00000001, 32'h00000000, 1'b0};
    vecs[11] = '{32'h00400000, 32'h00000000, 1'b0};
`endif
    vecs[12] = '{32'h80000001, 32'h7FC00000, 1'b1};
    vecs[13] = '{32'h3F800000, 32'h3F800000, 1'b0};
    vecs[14] = '{32'h7F7FFFFF, 32'h5F7FFFFF, 1'b0};
    vecs[15] = '{32'h00800000, 32'h20000000, 1'b0};
    vecs[16] = '{32'hFFC00001, 32'h7FC00000, 1'b1};
    vecs[17] = '{32'h7F800001, 32'h7FC00000, 1'b1};
    vecs[18] = '{32'h80800000, 32'h7FC00000, 1'b1};
    vecs[19] = '{32'h40800000, 32'h40000000, 1'b0};

    // Reset is held for two edges with a live operand on the inputs.
    rst = 1'b1;
    drive(32'h42800000);
    tick;
    check("reset_cycle1", 32'h00000000, 1'b0);
    tick;
    check("reset_cycle2", 32'h00000000, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick;
    check("first_after_reset", 32'h41000000, 1'b0);

    // The table is applied back to back, with a new operand on every cycle.
    // Before each edge the output must still hold the previous result.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(vecs[i].din);
      #1;
      if (i > 0) check($sformatf("hold_before_edge_%0d", i), vecs[i-1].dout, vecs[i-1].inc);
      tick;
      check($sformatf("vec_%0d_%08h", i, vecs[i].din), vecs[i].dout, vecs[i].inc);
    end

    // Asserting reset in the middle of the stream discards the result.
    @(negedge clk);
    drive(32'hC1200000);
    rst = 1'b1;
    tick;
    check("midstream_reset", 32'h00000000, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(32'h4745C100);
    tick;
    check("after_midstream_reset", 32'h4362E080, 1'b0);

    // When the input is unchanged, the output holds over further edges.
    tick;
    check("steady_hold", 32'h4362E080, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
